// File: rtl/briey_loader_pkg.sv
// Shared constants and types for the Briey program loader.
// Register offsets, CTRL/STATUS bit positions and the AXI-Lite FSM state type.
package briey_loader_pkg;

  localparam logic [31:0] REG_ID         = 32'h00;
  localparam logic [31:0] REG_CTRL       = 32'h10;
  localparam logic [31:0] REG_LINE_ADDR  = 32'h20;
  localparam logic [31:0] REG_WORD_IDX   = 32'h30;
  localparam logic [31:0] REG_DATA       = 32'h40;
  localparam logic [31:0] REG_FLUSH      = 32'h50;
  localparam logic [31:0] REG_STATUS     = 32'h60;
  localparam logic [31:0] REG_LINES_DONE = 32'h70;

  localparam logic [63:0] DEFAULT_ID     = 64'hb0b1b2b3_10ad0002;
  localparam logic [63:0] UNMAPPED_VALUE = 64'hdeaddead_deaddead;

  localparam int CTRL_LOAD_EN_BIT  = 0;
  localparam int CTRL_AUTO_INC_BIT = 1;
  localparam int CTRL_CLEAR_BIT    = 2;

  localparam int STATUS_OVF_BIT    = 63;
  localparam int STATUS_FULL_BIT   = 62;
  localparam int STATUS_EMPTY_BIT  = 61;

  typedef enum logic [1:0] {
    AXIL_IDLE,
    AXIL_READ,
    AXIL_WRITE_W,
    AXIL_WRITE_B
  } axil_state_t;

endpackage

// File: rtl/axil_bus_t.sv
// AXI-Lite register bus, 32-bit address, 64-bit data.
// Pure wiring; handshake timing is owned by the slave.
interface axil_bus_t;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/briey_line_fifo.sv
// Generic synchronous FIFO: registered storage, head visible one cycle after push.
// Push ignored when full, pop ignored when empty; clear wins over push/pop.
module briey_line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/briey_prog_loader.sv
// AXI-Lite staged line loader feeding the Briey RAM reload port through a line FIFO.
// Lines reach prog_* one cycle after push; a push into a full FIFO stalls wready (load_en) or drops.
module briey_prog_loader
  import briey_loader_pkg::*;
#(
  parameter int          DATA_W   = 512,
  parameter int          ADDR_W   = 15,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] ID_VALUE = DEFAULT_ID
) (
  input  logic                      axi4_mm_clk,
  input  logic                      axi4_mm_rst,
  axil_bus_t.slave                  axil,
  output logic                      prog_en,
  output logic                      prog_aw_valid,
  input  logic                      prog_aw_ready,
  output logic [ADDR_W-1:0]         prog_aw_addr,
  output logic                      prog_w_valid,
  input  logic                      prog_w_ready,
  output logic [DATA_W-1:0]         prog_w_data,
  output logic [DATA_W/8-1:0]       prog_w_strb,
  output logic [$clog2(DEPTH):0]    q_level
);

  localparam int NW      = DATA_W / 64;
  localparam int IDX_W   = (NW > 1) ? $clog2(NW) : 1;
  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W + STRB_W;

  axil_state_t       state, state_nxt;
  logic [31:0]       waddr;
  logic [63:0]       rdata_q, rd_mux, status_w;
  logic              load_en, auto_inc, overflow;
  logic [ADDR_W-1:0] line_addr;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] stage_data, stage_data_nxt;
  logic [STRB_W-1:0] stage_strb, stage_strb_nxt;
  logic [31:0]       lines_done;
  logic              aw_done, w_done;

  logic               is_data, is_flush, push_needed, w_hs, push_req, clear_req;
  logic               head_present, aw_hs, w_hs_prog, pop;
  logic               full, empty;
  logic [ENTRY_W-1:0] head_dat;

  assign is_data     = (state == AXIL_WRITE_W) && (waddr == REG_DATA);
  assign is_flush    = (state == AXIL_WRITE_W) && (waddr == REG_FLUSH);
  assign push_needed = (is_data && (word_idx == IDX_W'(NW - 1))) || (is_flush && |stage_strb);

  assign axil.wready  = (state == AXIL_WRITE_W) && !(push_needed && full && load_en);
  assign axil.awready = (state == AXIL_IDLE);
  assign axil.arready = (state == AXIL_IDLE);
  assign axil.rvalid  = (state == AXIL_READ);
  assign axil.bvalid  = (state == AXIL_WRITE_B);
  assign axil.rdata   = rdata_q;
  assign axil.bresp   = 2'b00;
  assign axil.rresp   = 2'b00;

  assign w_hs      = axil.wvalid && axil.wready;
  assign push_req  = w_hs && push_needed;
  assign clear_req = w_hs && (waddr == REG_CTRL) && axil.wdata[CTRL_CLEAR_BIT];

  // The pushed line must include the word carried by the same DATA write.
  always_comb begin
    stage_data_nxt = stage_data;
    stage_strb_nxt = stage_strb;
    if (is_data) begin
      stage_data_nxt[int'(word_idx)*64 +: 64] = axil.wdata;
      stage_strb_nxt[int'(word_idx)*8 +: 8]   = 8'hFF;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AXIL_IDLE:    if (axil.awvalid) state_nxt = AXIL_WRITE_W;
                    else if (axil.arvalid) state_nxt = AXIL_READ;
      AXIL_READ:    if (axil.rready) state_nxt = AXIL_IDLE;
      AXIL_WRITE_W: if (w_hs) state_nxt = AXIL_WRITE_B;
      AXIL_WRITE_B: if (axil.bready) state_nxt = AXIL_IDLE;
      default:      state_nxt = AXIL_IDLE;
    endcase
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) state <= AXIL_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    status_w                   = '0;
    status_w[LVL_W-1:0]        = q_level;
    status_w[STATUS_EMPTY_BIT] = empty;
    status_w[STATUS_FULL_BIT]  = full;
    status_w[STATUS_OVF_BIT]   = overflow;
  end

  always_comb begin
    rd_mux = UNMAPPED_VALUE;
    case (axil.araddr)
      REG_ID:         rd_mux = ID_VALUE;
      REG_CTRL:       rd_mux = {62'b0, auto_inc, load_en};
      REG_LINE_ADDR:  rd_mux = 64'(line_addr);
      REG_WORD_IDX:   rd_mux = 64'(word_idx);
      REG_STATUS:     rd_mux = status_w;
      REG_LINES_DONE: rd_mux = {32'b0, lines_done};
      default:        ;
    endcase
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      waddr      <= '0;
      rdata_q    <= '0;
      load_en    <= 1'b0;
      auto_inc   <= 1'b0;
      overflow   <= 1'b0;
      line_addr  <= '0;
      word_idx   <= '0;
      stage_data <= '0;
      stage_strb <= '0;
    end else begin
      if (state == AXIL_IDLE && axil.awvalid) waddr <= axil.awaddr;
      if (state == AXIL_IDLE && !axil.awvalid && axil.arvalid) rdata_q <= rd_mux;
      if (w_hs) begin
        case (waddr)
          REG_CTRL: begin
            load_en  <= axil.wdata[CTRL_LOAD_EN_BIT];
            auto_inc <= axil.wdata[CTRL_AUTO_INC_BIT];
            if (axil.wdata[CTRL_CLEAR_BIT]) begin
              stage_data <= '0;
              stage_strb <= '0;
              word_idx   <= '0;
            end
          end
          REG_LINE_ADDR: line_addr <= {axil.wdata[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          REG_WORD_IDX:  word_idx  <= axil.wdata[IDX_W-1:0];
          REG_DATA: begin
            stage_data <= stage_data_nxt;
            stage_strb <= stage_strb_nxt;
            word_idx   <= word_idx + 1'b1;
          end
          REG_STATUS:    overflow  <= 1'b0;
          default:       ;
        endcase
      end
      // Push bookkeeping overrides the per-word update above.
      if (push_req) begin
        stage_strb <= '0;
        word_idx   <= '0;
        if (auto_inc) line_addr <= line_addr + ADDR_W'(STRB_W);
        if (full) overflow <= 1'b1;
      end
    end
  end

  assign head_present  = load_en && !empty;
  assign prog_en       = load_en;
  assign prog_aw_valid = head_present && !aw_done;
  assign prog_w_valid  = head_present && !w_done;
  assign aw_hs         = prog_aw_valid && prog_aw_ready;
  assign w_hs_prog     = prog_w_valid && prog_w_ready;
  assign pop           = head_present && (aw_done || aw_hs) && (w_done || w_hs_prog);
  assign {prog_aw_addr, prog_w_data, prog_w_strb} = head_dat;

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      lines_done <= '0;
    end else begin
      if (clear_req || pop) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs)     aw_done <= 1'b1;
        if (w_hs_prog) w_done  <= 1'b1;
      end
      if (pop && !clear_req) lines_done <= lines_done + 1'b1;
    end
  end

  briey_line_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (axi4_mm_clk),
    .rst      (axi4_mm_rst),
    .push     (push_req && !full),
    .push_dat ({line_addr, stage_data_nxt, stage_strb_nxt}),
    .pop      (pop),
    .clear    (clear_req),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .level    (q_level)
  );

endmodule

// File: tb/tb_briey_prog_loader.sv
// Bench for briey_prog_loader: register vector table plus a scoreboard of drained lines.
module tb_briey_prog_loader;
  import briey_loader_pkg::*;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 512;
  localparam int STRB_W = 64;
  localparam int DEPTH  = 4;
  localparam logic [63:0] EXP_ID     = 64'hb0b1b2b3_10ad0002;
  localparam logic [63:0] DEAD       = 64'hdeaddead_deaddead;
  localparam logic [63:0] ST_EMPTY   = 64'h2000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_bus_t axil ();
  logic                prog_en, prog_aw_valid, prog_aw_ready, prog_w_valid, prog_w_ready;
  logic [ADDR_W-1:0]   prog_aw_addr;
  logic [DATA_W-1:0]   prog_w_data;
  logic [STRB_W-1:0]   prog_w_strb;
  logic [2:0]          q_level;

  briey_prog_loader dut (
    .axi4_mm_clk   (clk),
    .axi4_mm_rst   (rst),
    .axil          (axil),
    .prog_en       (prog_en),
    .prog_aw_valid (prog_aw_valid),
    .prog_aw_ready (prog_aw_ready),
    .prog_aw_addr  (prog_aw_addr),
    .prog_w_valid  (prog_w_valid),
    .prog_w_ready  (prog_w_ready),
    .prog_w_data   (prog_w_data),
    .prog_w_strb   (prog_w_strb),
    .q_level       (q_level)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } line_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] dat;
    string       name;
  } vec_t;

  line_t exp_q[$];
  vec_t  vt[$];
  int    nvec = 0;
  int    nerr = 0;
  bit    keep = 1'b1;

  logic [DATA_W-1:0] stage_m;
  logic [STRB_W-1:0] strb_m;
  logic [ADDR_W-1:0] addr_m;
  logic [2:0]        idx_m;
  logic              auto_m;

  task automatic check(input string n, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic expired(input string n, input int cycles);
    nvec++;
    nerr++;
    $display("FAIL %s: no handshake within %0d cycles", n, cycles);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axil_write(input logic [31:0] a, input logic [63:0] d);
    int n;
    axil.awaddr = a; axil.awvalid = 1'b1;
    n = 0;
    while (!axil.awready && n < 200) begin tick(); n++; end
    if (n >= 200) expired("aw_wait", n);
    tick(); axil.awvalid = 1'b0;
    axil.wdata = d; axil.wvalid = 1'b1;
    n = 0;
    while (!axil.wready && n < 200) begin tick(); n++; end
    if (n >= 200) expired("w_wait", n);
    tick(); axil.wvalid = 1'b0;
    axil.bready = 1'b1;
    n = 0;
    while (!axil.bvalid && n < 200) begin tick(); n++; end
    if (n >= 200) expired("b_wait", n);
    tick(); axil.bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [63:0] d);
    int n;
    axil.araddr = a; axil.arvalid = 1'b1;
    n = 0;
    while (!axil.arready && n < 200) begin tick(); n++; end
    if (n >= 200) expired("ar_wait", n);
    tick(); axil.arvalid = 1'b0;
    axil.rready = 1'b1;
    n = 0;
    while (!axil.rvalid && n < 200) begin tick(); n++; end
    if (n >= 200) expired("r_wait", n);
    d = axil.rdata;
    tick(); axil.rready = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [63:0] exp, input string n);
    logic [63:0] d;
    axil_read(a, d);
    check(n, d, exp);
  endtask

  task automatic push_m();
    if (keep) exp_q.push_back('{addr_m, stage_m, strb_m});
    strb_m = '0;
    idx_m  = '0;
    if (auto_m) addr_m = addr_m + 15'h40;
  endtask

  // Model update happens before the bus write so the expectation is queued first.
  task automatic reg_wr(input logic [31:0] a, input logic [63:0] d);
    case (a)
      REG_CTRL: begin
        auto_m = d[1];
        if (d[2]) begin stage_m = '0; strb_m = '0; idx_m = '0; end
      end
      REG_LINE_ADDR: addr_m = d[14:0] & 15'h7FC0;
      REG_WORD_IDX:  idx_m = d[2:0];
      REG_DATA: begin
        stage_m[int'(idx_m)*64 +: 64] = d;
        strb_m[int'(idx_m)*8 +: 8]    = 8'hFF;
        if (idx_m == 3'd7) push_m(); else idx_m = idx_m + 3'd1;
      end
      REG_FLUSH: if (strb_m != '0) push_m();
      default: ;
    endcase
    axil_write(a, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    stage_m = '0; strb_m = '0; addr_m = '0; idx_m = '0; auto_m = 1'b0;
  endtask

  task automatic monitor();
    bit                got_aw, got_w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    line_t             e;
    got_aw = 0; got_w = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        got_aw = 0; got_w = 0;
      end else begin
        if (prog_aw_valid && prog_aw_ready) begin got_aw = 1; a = prog_aw_addr; end
        if (prog_w_valid && prog_w_ready) begin got_w = 1; d = prog_w_data; s = prog_w_strb; end
        if (got_aw && got_w) begin
          got_aw = 0; got_w = 0;
          if (exp_q.size() == 0) check("line_expected", 0, 1);
          else begin
            e = exp_q.pop_front();
            check("line_addr", a, e.addr);
            check("line_data", d, e.data);
            check("line_strb", s, e.strb);
          end
        end
      end
    end
  endtask

  initial begin
    axil.awvalid = 0; axil.awaddr = 0; axil.wvalid = 0; axil.wdata = 0; axil.bready = 0;
    axil.arvalid = 0; axil.araddr = 0; axil.rready = 0;
    prog_aw_ready = 1'b1; prog_w_ready = 1'b1;
    fork monitor(); join_none
    do_reset();

    check("rst_q_level", q_level, 0);
    check("rst_prog_en", prog_en, 0);
    check("rst_aw_valid", prog_aw_valid, 0);
    check("rst_w_valid", prog_w_valid, 0);
    check("rst_aw_addr", prog_aw_addr, 0);
    check("rst_w_data", prog_w_data, 0);
    check("rst_w_strb", prog_w_strb, 0);

    vt.push_back('{0, REG_ID,         EXP_ID,   "id"});
    vt.push_back('{0, REG_STATUS,     ST_EMPTY, "status_reset"});
    vt.push_back('{0, 32'h88,         DEAD,     "unmapped_rd"});
    vt.push_back('{0, REG_CTRL,       64'd0,    "ctrl_reset"});
    vt.push_back('{0, REG_LINES_DONE, 64'd0,    "lines_reset"});
    vt.push_back('{1, 32'h88,         64'h1234, ""});
    vt.push_back('{0, 32'h88,         DEAD,     "unmapped_after_wr"});
    vt.push_back('{1, REG_CTRL,       64'd3,    ""});
    vt.push_back('{0, REG_CTRL,       64'd3,    "ctrl_rb"});
    vt.push_back('{1, REG_LINE_ADDR,  64'h47,   ""});
    vt.push_back('{0, REG_LINE_ADDR,  64'h40,   "line_addr_mask"});
    vt.push_back('{1, REG_WORD_IDX,   64'hFFFF_FFFF_FFFF_FFFB, ""});
    vt.push_back('{0, REG_WORD_IDX,   64'd3,    "word_idx_mask"});
    vt.push_back('{1, REG_WORD_IDX,   64'd0,    ""});
    vt.push_back('{0, REG_PROG_EN_CHECK_ADDR(), 64'd3, "ctrl_hold"});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) reg_wr(vt[i].addr, vt[i].dat);
      else rd_chk(vt[i].addr, vt[i].dat, vt[i].name);
    end

    // Full line of eight words.
    for (int w = 0; w < 8; w++) reg_wr(REG_DATA, 64'(w));
    repeat (4) tick();
    rd_chk(REG_LINE_ADDR, 64'h80, "full_line_addr_inc");
    rd_chk(REG_LINES_DONE, 64'd1, "full_line_done");
    rd_chk(REG_STATUS, ST_EMPTY, "full_line_empty");

    // Partial flush of word 5 only.
    reg_wr(REG_WORD_IDX, 64'd5);
    reg_wr(REG_DATA, 64'hAA);
    check("partial_strb_model", strb_m, 64'h0000_FF00_0000_0000);
    reg_wr(REG_FLUSH, 64'd0);
    repeat (4) tick();
    rd_chk(REG_WORD_IDX, 64'd0, "flush_idx_reset");

    // Split AW/W handshake.
    prog_w_ready = 1'b0;
    reg_wr(REG_DATA, 64'h55);
    reg_wr(REG_FLUSH, 64'd0);
    begin
      int n;
      n = 0;
      while (!(prog_w_valid && !prog_aw_valid) && n < 50) begin tick(); n++; end
      if (n >= 50) expired("split_aw_done", n);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      check("split_aw_low", prog_aw_valid, 0);
      check("split_w_high", prog_w_valid, 1);
      check("split_no_pop", q_level, 1);
    end
    prog_w_ready = 1'b1;
    check("split_pre_pop", q_level, 1);
    tick();
    check("split_popped", q_level, 0);
    repeat (3) tick();
    check("pre_reset_queue", exp_q.size(), 0);

    // Backpressure: four lines fill the FIFO, the fifth stalls on its last word.
    do_reset();
    reg_wr(REG_CTRL, 64'd3);
    reg_wr(REG_LINE_ADDR, 64'h100);
    prog_aw_ready = 1'b0; prog_w_ready = 1'b0;
    for (int l = 0; l < 4; l++)
      for (int w = 0; w < 8; w++) reg_wr(REG_DATA, 64'(l * 16 + w));
    check("bp_full_level", q_level, 4);
    for (int w = 0; w < 7; w++) reg_wr(REG_DATA, 64'(64 + w));
    fork
      reg_wr(REG_DATA, 64'(64 + 7));
      begin
        repeat (6) tick();
        check("bp_wready_low", axil.wready, 0);
        check("bp_level_held", q_level, 4);
        prog_aw_ready = 1'b1; prog_w_ready = 1'b1;
      end
    join
    repeat (8) tick();
    rd_chk(REG_LINES_DONE, 64'd5, "bp_lines_done");
    rd_chk(REG_STATUS, ST_EMPTY, "bp_empty");

    // Overflow with load_en clear, plus address wrap.
    reg_wr(REG_CTRL, 64'd2);
    reg_wr(REG_LINE_ADDR, 64'h7F00);
    for (int l = 0; l < 4; l++) begin
      reg_wr(REG_DATA, 64'(l + 'h900));
      reg_wr(REG_FLUSH, 64'd0);
    end
    rd_chk(REG_LINE_ADDR, 64'h0, "addr_wrap");
    keep = 1'b0;
    reg_wr(REG_DATA, 64'h999);
    reg_wr(REG_FLUSH, 64'd0);
    keep = 1'b1;
    rd_chk(REG_STATUS, 64'hC000_0000_0000_0004, "ovf_status");
    rd_chk(REG_WORD_IDX, 64'd0, "ovf_idx_reset");
    rd_chk(REG_LINE_ADDR, 64'h40, "ovf_addr_adv");
    check("ovf_no_drain", prog_aw_valid, 0);
    reg_wr(REG_STATUS, 64'd0);
    rd_chk(REG_STATUS, 64'h4000_0000_0000_0004, "ovf_cleared");
    reg_wr(REG_CTRL, 64'd3);
    repeat (8) tick();
    rd_chk(REG_LINES_DONE, 64'd9, "ovf_drain_done");

    // Clear empties FIFO and stage; later empty flush pushes nothing.
    reg_wr(REG_CTRL, 64'd2);
    keep = 1'b0;
    reg_wr(REG_DATA, 64'h11);
    reg_wr(REG_FLUSH, 64'd0);
    check("clr_level_before", q_level, 1);
    reg_wr(REG_DATA, 64'h22);
    reg_wr(REG_CTRL, 64'd6);
    check("clr_level_after", q_level, 0);
    rd_chk(REG_WORD_IDX, 64'd0, "clr_idx");
    reg_wr(REG_FLUSH, 64'd0);
    check("clr_flush_noop", q_level, 0);
    rd_chk(REG_CTRL, 64'd2, "clr_self_clear");
    keep = 1'b1;
    reg_wr(REG_CTRL, 64'd3);
    repeat (4) tick();
    check("clr_nothing_drains", prog_aw_valid, 0);
    check("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  function automatic logic [31:0] REG_PROG_EN_CHECK_ADDR();
    return REG_CTRL;
  endfunction

endmodule
